// File: rtl/char_normalizer.sv
// rtl/char_normalizer.sv - ASCII normalizer: lowercase, collapse whitespace, drop non-printables, FIFO output
module char_normalizer #(
    parameter int DEPTH = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    input  logic [7:0]  in_char,
    output logic        in_ready,
    output logic        out_valid,
    output logic [7:0]  out_char,
    input  logic        out_ready,
    output logic [15:0] drop_cnt
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_COUNT = (AW+1)'(DEPTH);

    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;
    logic          last_ws;

    logic       is_upper;
    logic       is_ws;
    logic       is_print;
    logic       is_bad;
    logic [7:0] norm_char;
    logic       accept;
    logic       push;
    logic       pop;

    always_comb begin
        is_upper  = (in_char >= 8'h41) && (in_char <= 8'h5A);
        is_ws     = (in_char == 8'h20) || (in_char == 8'h09) ||
                    (in_char == 8'h0A) || (in_char == 8'h0D);
        is_print  = (in_char >= 8'h21) && (in_char <= 8'h7E) && !is_upper;
        is_bad    = !(is_upper || is_ws || is_print);
        norm_char = in_char;
        if (is_upper) begin
            norm_char = in_char + 8'h20;
        end else if (is_ws) begin
            norm_char = 8'h20;
        end
    end

    // Flow control depends only on registered occupancy, never on out_ready.
    assign in_ready  = (count < FULL_COUNT);
    assign out_valid = (count != '0);
    assign out_char  = mem[rd_ptr];

    assign accept = in_valid && in_ready;
    assign push   = accept && (is_upper || is_print || (is_ws && !last_ws));
    assign pop    = out_valid && out_ready;

    always_ff @(posedge clk) begin
        if (!reset) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            last_ws  <= 1'b1;
            drop_cnt <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            if (accept && !is_bad) begin
                last_ws <= is_ws;
            end
            if (accept && is_bad && (drop_cnt != 16'hFFFF)) begin
                drop_cnt <= drop_cnt + 16'd1;
            end
        end
    end

    // Storage is not reset; pointers and count define what is valid.
    always_ff @(posedge clk) begin
        if (reset && push) begin
            mem[wr_ptr] <= norm_char;
        end
    end

endmodule
